// File: rtl/uart_alu_pkt_parser.sv
// uart_alu_pkt_parser
// Parses byte-serial command packets from a UART receiver into a command
// header (opcode + total length) and a stream of little-endian 32-bit
// payload words for a downstream ALU.
//
// Packet: opcode, reserved, len LSB, len MSB, then len-4 payload bytes.
// Malformed headers raise a one-cycle err_o. Any payload that follows a
// malformed header is discarded.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   rx_data_i/rx_valid_i/rx_ready_o  byte input handshake
//   cmd_opcode_o/cmd_len_o/cmd_valid_o/cmd_ready_i  command header output
//   word_data_o/word_bytes_o/word_last_o/word_valid_o/word_ready_i
//                                  payload word output
//   err_o                          framing error pulse
module uart_alu_pkt_parser #(
    parameter logic [15:0] MAX_LEN = 16'd64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  cmd_opcode_o,
    output logic [15:0] cmd_len_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic [31:0] word_data_o,
    output logic [2:0]  word_bytes_o,
    output logic        word_last_o,
    output logic        word_valid_o,
    input  logic        word_ready_i,
    output logic        err_o
);

    typedef enum logic [2:0] {HDR0, HDR1, HDR2, HDR3, CMD, PAYLOAD, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [7:0]  lsb_q, lsb_d;
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        word_valid_q, word_valid_d;
    logic [31:0] word_data_q, word_data_d;
    logic [2:0]  word_bytes_q, word_bytes_d;
    logic        word_last_q, word_last_d;
    logic        err_q, err_d;
    // Keeps rx_ready_o low until the first clock edge after reset release.
    logic        live_q;

    logic [15:0] plen;
    logic [15:0] hdr_len;
    logic        rx_ready;
    logic        rx_fire;
    logic        word_fire;
    logic [1:0]  lane;

    function automatic logic hdr_ok(input logic [7:0] op, input logic [15:0] len);
        logic [15:0] pl;
        if (!(op == 8'hEC || op == 8'hA0 || op == 8'hA1 || op == 8'hA2)) return 1'b0;
        if (len < 16'd4 || len > MAX_LEN) return 1'b0;
        pl = len - 16'd4;
        // ALU operations need whole 32-bit operands, at least two of them.
        if (op != 8'hEC && (pl[1:0] != 2'b00 || pl < 16'd8)) return 1'b0;
        return 1'b1;
    endfunction

    assign plen      = len_q - 16'd4;
    assign hdr_len   = {rx_data_i, lsb_q};
    assign rx_fire   = rx_valid_i && rx_ready;
    assign word_fire = word_valid_q && word_ready_i;
    assign lane      = cnt_q[1:0];

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        lsb_d        = lsb_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        cmd_valid_d  = cmd_valid_q;
        word_valid_d = word_valid_q;
        word_data_d  = word_data_q;
        word_bytes_d = word_bytes_q;
        word_last_d  = word_last_q;
        err_d        = 1'b0;
        rx_ready     = 1'b0;

        if (word_fire) word_valid_d = 1'b0;

        case (state_q)
            HDR0: begin
                rx_ready = live_q;
                if (rx_fire) begin
                    opcode_d = rx_data_i;
                    state_d  = HDR1;
                end
            end
            HDR1: begin
                rx_ready = live_q;
                if (rx_fire) state_d = HDR2;
            end
            HDR2: begin
                rx_ready = live_q;
                if (rx_fire) begin
                    lsb_d   = rx_data_i;
                    state_d = HDR3;
                end
            end
            HDR3: begin
                rx_ready = live_q;
                if (rx_fire) begin
                    len_d = hdr_len;
                    cnt_d = 16'd0;
                    if (hdr_ok(opcode_q, hdr_len)) begin
                        cmd_valid_d = 1'b1;
                        state_d     = CMD;
                    end else begin
                        err_d = 1'b1;
                        // Nothing to drain when the length has no payload part.
                        state_d = (hdr_len <= 16'd4) ? HDR0 : DRAIN;
                    end
                end
            end
            CMD: begin
                if (cmd_valid_q && cmd_ready_i) begin
                    cmd_valid_d = 1'b0;
                    state_d     = (len_q == 16'd4) ? HDR0 : PAYLOAD;
                end
            end
            PAYLOAD: begin
                // Stop after the last payload byte so the next packet's
                // header is not swallowed while the final word is pending.
                rx_ready = live_q && (cnt_q != plen) && !(word_valid_q && !word_ready_i);
                if (rx_fire) begin
                    if (lane == 2'd0) acc_d = {24'd0, rx_data_i};
                    else              acc_d = acc_q | ({24'd0, rx_data_i} << {lane, 3'b000});
                    cnt_d = cnt_q + 16'd1;
                    if (lane == 2'd3 || cnt_q == plen - 16'd1) begin
                        word_valid_d = 1'b1;
                        word_data_d  = acc_d;
                        word_bytes_d = {1'b0, lane} + 3'd1;
                        word_last_d  = (cnt_q == plen - 16'd1);
                    end
                end
                if (word_fire && word_last_q) begin
                    cnt_d   = 16'd0;
                    state_d = HDR0;
                end
            end
            DRAIN: begin
                rx_ready = live_q;
                if (rx_fire) begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == plen - 16'd1) begin
                        cnt_d   = 16'd0;
                        state_d = HDR0;
                    end
                end
            end
            default: state_d = HDR0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= HDR0;
            opcode_q     <= 8'd0;
            lsb_q        <= 8'd0;
            len_q        <= 16'd0;
            cnt_q        <= 16'd0;
            acc_q        <= 32'd0;
            cmd_valid_q  <= 1'b0;
            word_valid_q <= 1'b0;
            word_data_q  <= 32'd0;
            word_bytes_q <= 3'd0;
            word_last_q  <= 1'b0;
            err_q        <= 1'b0;
            live_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            lsb_q        <= lsb_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            cmd_valid_q  <= cmd_valid_d;
            word_valid_q <= word_valid_d;
            word_data_q  <= word_data_d;
            word_bytes_q <= word_bytes_d;
            word_last_q  <= word_last_d;
            err_q        <= err_d;
            live_q       <= 1'b1;
        end
    end

    assign rx_ready_o   = rx_ready;
    assign cmd_opcode_o = opcode_q;
    assign cmd_len_o    = len_q;
    assign cmd_valid_o  = cmd_valid_q;
    assign word_data_o  = word_data_q;
    assign word_bytes_o = word_bytes_q;
    assign word_last_o  = word_last_q;
    assign word_valid_o = word_valid_q;
    assign err_o        = err_q;

endmodule
